// File: rtl/fifo_async_pkg.sv
// fifo_async_pkg
//   Shared definitions for the fifo_async block: default word/address
//   widths and the binary-to-Gray conversion used for the pointer copies.
package fifo_async_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Generic 32-bit conversion; callers size the argument and result to
  // their own pointer width with casts.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-stage register synchronizer for a multi-bit Gray-coded bus.
//   Ports:
//     i_clk   destination clock
//     i_rstn  asynchronous active-low reset, clears both stages to 0
//     i_d     bus to be synchronized
//     o_q     output of the second stage
module sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage1_reg;
  logic [WIDTH-1:0] stage2_reg;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stage1_reg <= '0;
      stage2_reg <= '0;
    end else begin
      stage1_reg <= i_d;
      stage2_reg <= stage1_reg;
    end
  end

  assign o_q = stage2_reg;

endmodule

// File: rtl/fifo_async.sv
// fifo_async
//   FIFO of 2**ADDR_WIDTH words built in the classic dual-pointer style:
//   binary pointers with registered Gray copies, each Gray copy crossing to
//   the other side through a two-stage synchronizer. Both flags are
//   conservative: they see the opposite pointer three edges late.
//   Ports:
//     i_clk     sole clock, all state on its rising edge
//     i_rstn    asynchronous active-low reset
//     i_wr      write request, accepted when o_wfull is low
//     i_wdata   write data, sampled with i_wr
//     i_rd      read request, accepted when o_rempty is low
//     o_rdata   registered read data, valid the cycle after acceptance
//     o_wfull   registered full flag
//     o_rempty  registered empty flag
module fifo_async
  import fifo_async_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_wfull,
  output logic                  o_rempty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  // Full when the write Gray pointer equals the read Gray pointer with its
  // two MSBs inverted (one lap ahead).
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wbin_reg, wgray_reg, rbin_reg, rgray_reg;
  logic [PTR_W-1:0]      wbin_next, wgray_next, rbin_next, rgray_next;
  logic [PTR_W-1:0]      wq2_rgray, rq2_wgray;
  logic                  wfull_reg, rempty_reg, run_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  wr_ok, rd_ok;

  // run_reg stays low through the first edge after reset release, so no
  // transfer can be accepted on the release edge itself.
  assign wr_ok = i_wr && !wfull_reg  && run_reg;
  assign rd_ok = i_rd && !rempty_reg && run_reg;

  assign wbin_next  = wbin_reg + PTR_W'(wr_ok);
  assign rbin_next  = rbin_reg + PTR_W'(rd_ok);
  assign wgray_next = PTR_W'(bin2gray(32'(wbin_next)));
  assign rgray_next = PTR_W'(bin2gray(32'(rbin_next)));

  sync_2ff #(.WIDTH(PTR_W)) u_sync_r2w (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (rgray_reg),
    .o_q    (wq2_rgray)
  );

  sync_2ff #(.WIDTH(PTR_W)) u_sync_w2r (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (wgray_reg),
    .o_q    (rq2_wgray)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run_reg    <= 1'b0;
      wbin_reg   <= '0;
      wgray_reg  <= '0;
      rbin_reg   <= '0;
      rgray_reg  <= '0;
      wfull_reg  <= 1'b0;
      rempty_reg <= 1'b1;
    end else begin
      run_reg    <= 1'b1;
      wbin_reg   <= wbin_next;
      wgray_reg  <= wgray_next;
      rbin_reg   <= rbin_next;
      rgray_reg  <= rgray_next;
      wfull_reg  <= (wgray_next == (wq2_rgray ^ FULL_MASK));
      rempty_reg <= (rgray_next == rq2_wgray);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem[wbin_reg[ADDR_WIDTH-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rdata_reg <= '0;
    end else if (rd_ok) begin
      rdata_reg <= mem[rbin_reg[ADDR_WIDTH-1:0]];
    end
  end

  assign o_rdata  = rdata_reg;
  assign o_wfull  = wfull_reg;
  assign o_rempty = rempty_reg;

endmodule

// File: tb/tb_fifo_async.sv
// tb_fifo_async
//   Directed and randomized stimulus for fifo_async, checked every cycle
//   against a queue-based reference model. The model tracks total accepted
//   writes/reads; each flag compares the local count against the opposite
//   count as it stood three edges earlier.
module tb_fifo_async;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          i_clk   = 1'b0;
  logic          i_rstn  = 1'b0;
  logic          i_wr    = 1'b0;
  logic          i_rd    = 1'b0;
  logic [DW-1:0] i_wdata = '0;
  logic [DW-1:0] o_rdata;
  logic          o_wfull;
  logic          o_rempty;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  fifo_async #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_wr     (i_wr),
    .i_wdata  (i_wdata),
    .i_rd     (i_rd),
    .o_rdata  (o_rdata),
    .o_wfull  (o_wfull),
    .o_rempty (o_rempty)
  );

  // Reference model state
  logic [DW-1:0] q[$];
  int            w_cnt, r_cnt;
  int            w_hist[3];   // write count after edges t-1, t-2, t-3
  int            r_hist[3];
  logic          exp_empty, exp_full;
  logic [DW-1:0] exp_rdata;
  bit            first_edge;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    w_cnt = 0;
    r_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      w_hist[i] = 0;
      r_hist[i] = 0;
    end
    exp_empty  = 1'b1;
    exp_full   = 1'b0;
    exp_rdata  = '0;
    first_edge = 1'b1;
  endtask

  // Called at a falling edge; reset asserts immediately and releases on a
  // later falling edge.
  task automatic apply_reset();
    i_wr   = 1'b0;
    i_rd   = 1'b0;
    i_rstn = 1'b0;
    #1;
    model_reset();
    check_val("rst_rempty", 32'(o_rempty), 32'(exp_empty));
    check_val("rst_wfull",  32'(o_wfull),  32'(exp_full));
    check_val("rst_rdata",  32'(o_rdata),  32'(exp_rdata));
    $display("t=%0t reset asserted: rdata=%02h empty=%0b full=%0b", $time, o_rdata, o_rempty, o_wfull);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, check just after it.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd);
    bit acc_w, acc_r;
    i_wr    = wr;
    i_wdata = wd;
    i_rd    = rd;
    @(posedge i_clk);
    acc_w = wr && !exp_full  && !first_edge;
    acc_r = rd && !exp_empty && !first_edge;
    if (acc_r && q.size() > 0) begin
      exp_rdata = q.pop_front();
      r_cnt++;
    end
    if (acc_w) begin
      q.push_back(wd);
      w_cnt++;
    end
    exp_empty = (r_cnt == w_hist[2]);
    exp_full  = ((w_cnt - r_hist[2]) == DEPTH);
    w_hist[2] = w_hist[1];
    w_hist[1] = w_hist[0];
    w_hist[0] = w_cnt;
    r_hist[2] = r_hist[1];
    r_hist[1] = r_hist[0];
    r_hist[0] = r_cnt;
    first_edge = 1'b0;
    #1;
    check_val("rdata",  32'(o_rdata),  32'(exp_rdata));
    check_val("rempty", 32'(o_rempty), 32'(exp_empty));
    check_val("wfull",  32'(o_wfull),  32'(exp_full));
    $display("t=%0t wr=%0b wd=%02h rd=%0b -> rdata=%02h empty=%0b full=%0b",
             $time, wr, wd, rd, o_rdata, o_rempty, o_wfull);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    @(negedge i_clk);
    apply_reset();

    // Single word: empty latency, then read back.
    step(1'b1, 8'hA5, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b1);
    idle(1);

    // Fill to full, writes on full, then one read frees a slot.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b1, 8'hFF, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1);
    idle(3);
    step(1'b1, 8'h80, 1'b0);
    idle(2);

    // Drain completely, then read on empty.
    for (int i = 0; i < 22; i++) step(1'b0, '0, 1'b1);

    // Continuous simultaneous traffic across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    idle(3);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

    // Reset with words stored discards them.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    idle(3);
    apply_reset();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h3D, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    idle(1);

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int k = 0; k < 600; k++) begin
      int  wr_pct;
      int  rd_pct;
      wr_pct = ((k / 50) % 2 == 0) ? 85 : 25;
      rd_pct = ((k / 50) % 2 == 0) ? 25 : 85;
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 99) < wr_pct, 8'($urandom), $urandom_range(0, 99) < rd_pct);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
